// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: fetches frame-buffer samples three pixels ahead of the VGA counters
// and emits colour-moded pixels aligned with the displayed coordinate.
module vga_pixel_fetch #(
    parameter int          IMG_W  = 320,
    parameter int          IMG_H  = 240,
    parameter int          X0     = 160,
    parameter int          Y0     = 120,
    parameter int          ADDR_W = 17,
    parameter logic [23:0] BORDER = 24'h202020
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    input  logic [1:0]        mode,
    input  logic [7:0]        thr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        final_pixel_r,
    output logic [7:0]        final_pixel_g,
    output logic [7:0]        final_pixel_b,
    output logic              frame_start
);
    typedef enum logic [1:0] {C_BLANK, C_BORDER, C_WIN} cls_t;

    localparam logic [9:0] XL = 10'(X0);
    localparam logic [9:0] XH = 10'(X0 + IMG_W);
    localparam logic [9:0] YL = 10'(Y0);
    localparam logic [9:0] YH = 10'(Y0 + IMG_H);

    logic [10:0]       xs;
    logic [9:0]        xa, ya;
    logic              wrap, blank, win, la00;
    cls_t              cls1_d, cls1_q, cls2_q;
    logic [ADDR_W-1:0] mem_addr_d, mem_addr_q, addr_cnt_d, addr_cnt_q;
    logic              mem_rd_d, mem_rd_q, fs_d, fs_q;
    logic [1:0]        act_mode_d, act_mode_q;
    logic [7:0]        act_thr_d, act_thr_q, thr_hit;
    logic [23:0]       win_pix, pix_d, pix_q;

    always_comb begin
        xs    = {1'b0, hcount} + 11'd3;
        wrap  = xs >= 11'd800;
        xa    = wrap ? 10'(xs - 11'd800) : xs[9:0];
        ya    = wrap ? (vcount == 10'd524 ? 10'd0 : vcount + 10'd1) : vcount;
        blank = xa >= 10'd640 || ya >= 10'd480;
        win   = xa >= XL && xa < XH && ya >= YL && ya < YH;
        la00  = xa == 10'd0 && ya == 10'd0;
        cls1_d = blank ? C_BLANK : (win ? C_WIN : C_BORDER);
        // Window origin forces address 0 so addressing self-aligns every frame.
        mem_addr_d = win ? ((xa == XL && ya == YL) ? '0 : addr_cnt_q) : mem_addr_q;
        addr_cnt_d = win ? mem_addr_d + ADDR_W'(1) : addr_cnt_q;
        mem_rd_d   = win;
        act_mode_d = la00 ? mode : act_mode_q;
        act_thr_d  = la00 ? thr : act_thr_q;
        fs_d       = hcount == 10'd799 && vcount == 10'd524;
        thr_hit    = mem_rdata >= act_thr_q ? 8'hFF : 8'h00;
        win_pix    = act_mode_q == 2'd0 ? {3{mem_rdata}} :
                     act_mode_q == 2'd1 ? {3{~mem_rdata}} :
                     act_mode_q == 2'd2 ? {3{thr_hit}} :
                     {mem_rdata[7:5], mem_rdata[7:5], mem_rdata[7:6],
                      mem_rdata[4:2], mem_rdata[4:2], mem_rdata[4:3],
                      {4{mem_rdata[1:0]}}};
        pix_d = cls2_q == C_WIN ? win_pix : (cls2_q == C_BORDER ? BORDER : 24'h0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr_q <= '0;
            addr_cnt_q <= '0;
            mem_rd_q   <= 1'b0;
            cls1_q     <= C_BLANK;
            cls2_q     <= C_BLANK;
            act_mode_q <= 2'd0;
            act_thr_q  <= 8'd0;
            pix_q      <= 24'h0;
            fs_q       <= 1'b0;
        end else begin
            mem_addr_q <= mem_addr_d;
            addr_cnt_q <= addr_cnt_d;
            mem_rd_q   <= mem_rd_d;
            cls1_q     <= cls1_d;
            cls2_q     <= cls1_q;
            act_mode_q <= act_mode_d;
            act_thr_q  <= act_thr_d;
            pix_q      <= pix_d;
            fs_q       <= fs_d;
        end
    end

    assign mem_addr      = mem_addr_q;
    assign mem_rd        = mem_rd_q;
    assign final_pixel_r = pix_q[23:16];
    assign final_pixel_g = pix_q[15:8];
    assign final_pixel_b = pix_q[7:0];
    assign frame_start   = fs_q;
endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb_vga_pixel_fetch: directed checks of vga_pixel_fetch with a synchronous RAM model
// and testbench-driven VGA counters.
module tb_vga_pixel_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  hc = 10'd0, vc = 10'd0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  thr = 8'd0;
    logic [16:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata = 8'd0;
    logic [7:0]  r, g, b;
    logic        frame_start;
    logic [7:0]  mem [0:131071];
    int          checks = 0, errors = 0;

    vga_pixel_fetch dut (
        .clk(clk), .rst(rst), .hcount(hc), .vcount(vc), .mode(mode), .thr(thr),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .final_pixel_r(r), .final_pixel_g(g), .final_pixel_b(b),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;
    always @(posedge clk) mem_rdata <= mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (hc == 10'd799) begin
            hc = 10'd0;
            vc = (vc == 10'd524) ? 10'd0 : vc + 10'd1;
        end else hc = hc + 10'd1;
    endtask

    task automatic go(input int h, input int v);
        hc = 10'(h);
        vc = 10'(v);
    endtask

    task automatic run_to(input int h, input int v);
        int n = 0;
        while (!(hc == 10'(h) && vc == 10'(v)) && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) chk("run_to timeout", 0, 1);
    endtask

    task automatic fill(input logic [7:0] val);
        for (int i = 0; i < 76800; i++) mem[i] = val;
    endtask

    task automatic new_frame(input logic [1:0] m, input logic [7:0] t);
        mode = m;
        thr  = t;
        go(796, 524);
        run_to(0, 0);
    endtask

    function automatic logic [23:0] pix();
        return {r, g, b};
    endfunction

    initial begin
        logic any_rd;
        for (int i = 0; i < 131072; i++) mem[i] = 8'(i);
        #1 rst = 1'b1;
        tick(); tick();
        chk("rst pixel", pix(), 24'h0);
        chk("rst addr", mem_addr, 0);
        chk("rst rd", mem_rd, 0);
        chk("rst fs", frame_start, 0);
        rst = 1'b0;
        go(150, 120);
        run_to(159, 120);
        chk("border 159", pix(), 24'h202020);
        tick();
        chk("win 160", pix(), 24'h000000);
        tick();
        chk("win 161", pix(), 24'h010101);
        run_to(477, 120);
        chk("addr 319", mem_addr, 319);
        chk("rd 479", mem_rd, 1);
        run_to(640, 120);
        chk("blank 640", pix(), 24'h0);
        run_to(158, 121);
        chk("addr 320", mem_addr, 320);
        run_to(170, 121);
        chk("ramp 170,121", pix(), 24'h4A4A4A);
        go(290, 200);
        run_to(300, 200);
        #2 rst = 1'b1;
        #1;
        chk("async rst pixel", pix(), 24'h0);
        chk("async rst rd", mem_rd, 0);
        chk("async rst addr", mem_addr, 0);
        tick(); tick();
        rst = 1'b0;
        go(150, 120);
        run_to(160, 120);
        chk("post rst mem0", pix(), 24'h000000);
        run_to(165, 120);
        chk("post rst mem5", pix(), 24'h050505);
        go(797, 359);
        any_rd = 1'b0;
        for (int i = 0; i < 800; i++) begin
            tick();
            any_rd = any_rd | mem_rd;
        end
        chk("line 360 rd", any_rd, 0);
        go(790, 119);
        run_to(1, 120);
        chk("hwrap border", pix(), 24'h202020);
        go(795, 524);
        run_to(798, 524);
        chk("wrap rd", mem_rd, 0);
        tick();
        chk("fs before", frame_start, 0);
        tick();
        chk("fs pulse", frame_start, 1);
        tick();
        chk("fs after", frame_start, 0);
        fill(8'h00);
        go(150, 200);
        tick();
        mode = 2'd1;
        run_to(170, 200);
        chk("mode midframe", pix(), 24'h000000);
        new_frame(2'd1, 8'h00);
        go(150, 120);
        run_to(160, 120);
        chk("mode next frame", pix(), 24'hFFFFFF);
        fill(8'h80);
        new_frame(2'd2, 8'h80);
        go(150, 200);
        run_to(170, 200);
        chk("thr eq", pix(), 24'hFFFFFF);
        new_frame(2'd2, 8'h81);
        go(150, 200);
        run_to(170, 200);
        chk("thr above", pix(), 24'h000000);
        new_frame(2'd1, 8'h00);
        go(150, 200);
        run_to(170, 200);
        chk("invert 80", pix(), 24'h7F7F7F);
        new_frame(2'd0, 8'h00);
        go(150, 200);
        run_to(170, 200);
        chk("gray 80", pix(), 24'h808080);
        fill(8'hE0);
        new_frame(2'd3, 8'h00);
        go(150, 200);
        run_to(170, 200);
        chk("rgb332 E0", pix(), 24'hFF0000);
        fill(8'h03);
        go(150, 200);
        run_to(170, 200);
        chk("rgb332 03", pix(), 24'h0000FF);
        fill(8'h1C);
        go(150, 200);
        run_to(170, 200);
        chk("rgb332 1C", pix(), 24'h00FF00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
